panel_io: RTL and testbench
===========================

# panel_io

Parametrised front-panel I/O block for the board top level. It conditions N active-low push-buttons into debounced levels plus one-cycle press/release pulses. It drives N seven-segment digits with per-digit blanking, per-digit blinking and optional leading-zero suppression. It sits between the board pins and the `control` core and replaces the per-key debounce and per-digit display instances.

## Interface

Parameters:
- `N_KEYS`, 4, number of push-button channels (1..8)
- `DEB_CYCLES`, 16, consecutive stable synchronised samples required to accept a key change (≥2)
- `N_DIGITS`, 6, number of seven-segment digits (1..8)
- `BLINK_DIV`, 25000000, clock cycles per blink half-period (≥2)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `key_n`  in  N_KEYS  raw buttons, active-low, asynchronous to `clk`
- `key_level`  out  N_KEYS  debounced state, 1 = pressed
- `key_press`  out  N_KEYS  one-cycle pulse on accepted press
- `key_release`  out  N_KEYS  one-cycle pulse on accepted release
- `hex_data`  in  4*N_DIGITS  nibble per digit; digit i = bits [4i+3:4i]
- `hex_blank`  in  N_DIGITS  1 = digit i forced off
- `hex_blink`  in  N_DIGITS  1 = digit i shown only in the visible blink phase
- `lz_en`  in  1  1 = suppress leading zeros
- `hex_seg`  out  7*N_DIGITS  active-low segments, digit i = bits [7i+6:7i], order gfedcba

## Operation

- Key path, per channel: 2-flop synchroniser on `~key_n[k]` gives `s`. A counter `cnt` is sized for DEB_CYCLES-1.
  - If `s == key_level[k]`: `cnt <= 0`.
  - Else if `cnt == DEB_CYCLES-1`: `key_level[k] <= s`, `cnt <= 0`, and either `key_press[k]` (new level 1) or `key_release[k]` (new level 0) is asserted for exactly that following cycle.
  - Else: `cnt <= cnt+1`.
- Any glitch shorter than DEB_CYCLES synchronised samples resets `cnt` and produces no pulse. Channels are fully independent; simultaneous events on several keys pulse together.
- Blink timer: `bcnt` counts 0..BLINK_DIV-1 and wraps. `phase` toggles on each wrap. `phase = 1` is the visible phase.
- Leading-zero flag for digit i (i ≥ 1): `lz_en` = 1 and all nibbles from N_DIGITS-1 down to i are 0. Digit 0 is never suppressed, so all-zero data shows "0".
- Digit i is off (7'h7F) if any of these holds: `hex_blank[i]`; (`hex_blink[i]` and `phase` = 0); leading-zero flag set. Otherwise the digit shows its decoded nibble.
- Decode table (active-low gfedcba), nibble 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.

## Timing

- Reset values: `key_level` = 0, `key_press` = `key_release` = 0, all `cnt` = 0, synchroniser flops = 0, `bcnt` = 0, `phase` = 1, `hex_seg` = all ones (all digits off).
- Key latency: an input edge that stays stable produces its `key_press`/`key_release` pulse DEB_CYCLES+2 cycles after the first clock edge that samples the new raw value (2 synchroniser cycles + DEB_CYCLES). `key_level` changes in the same cycle as the pulse.
- Pulses never assert in two consecutive cycles on one channel.
- `hex_seg` is registered: it reflects `hex_data`/`hex_blank`/`hex_blink`/`lz_en`/`phase` sampled at the previous edge (1-cycle latency).
- `phase` toggles on the edge where `bcnt` wraps from BLINK_DIV-1 to 0. A blinking digit is visible for BLINK_DIV cycles, then off for BLINK_DIV cycles.
- Reset mid-debounce: the count is abandoned and no pulse is issued. After release, a held key yields a press pulse DEB_CYCLES+2 cycles later.
- Reset mid-blink: `phase` returns to 1 and `bcnt` to 0. The first `hex_seg` after reset deasserts is the normal decode on the following edge.
- Reset asserted together with a qualifying key change: reset wins and no pulse is issued.

## Test plan

Bench parameters: DEB_CYCLES=4, BLINK_DIV=8, N_KEYS=2, N_DIGITS=4.

- Reset, then `key_n` = 2'b11 held → all key outputs 0, `hex_seg` = all 7'h7F during reset, `phase` = 1.
- `key_n[0]` low from cycle 10, held → `key_press[0]` high only in cycle 16, `key_level[0]` = 1 from 16. Release at cycle 30 → `key_release[0]` only in cycle 36.
- Glitch: `key_n[1]` low for 3 cycles, then high → no pulses, `key_level[1]` stays 0. Both keys pressed in the same cycle → both press pulses in the same cycle.
- `hex_data` = 16'h00A0, `lz_en` = 1 → digits 3,2 = 7F, digit 1 = 08, digit 0 = 40. With `lz_en` = 0 → 40,40,08,40. `hex_data` = 0 with `lz_en` = 1 → only digit 0 shows 40.
- `hex_blink` = 4'b0001, `hex_data` = 16'h1234 → digit 0 alternates 19 (8 cycles) / 7F (8 cycles). `hex_blank[3]` = 1 → digit 3 = 7F constantly.
- Reset asserted 2 cycles into a key debounce and during the blink-off phase → no pulse, `phase` = 1, and digit 0 is visible on the edge after reset deasserts.

Source files
------------

// File: rtl/panel_io.sv
// panel_io: front-panel key debounce with press/release pulses and a
// seven-segment driver with per-digit blank/blink and leading-zero suppression.
// Ports:
//   clk, reset (sync, active-high)
//   key_n -> key_level / key_press / key_release
//   hex_data, hex_blank, hex_blink, lz_en -> hex_seg (active-low gfedcba)
module panel_io #(
    parameter int N_KEYS     = 4,
    parameter int DEB_CYCLES = 16,
    parameter int N_DIGITS   = 6,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_KEYS-1:0]     key_n,
    output logic [N_KEYS-1:0]     key_level,
    output logic [N_KEYS-1:0]     key_press,
    output logic [N_KEYS-1:0]     key_release,
    input  logic [4*N_DIGITS-1:0] hex_data,
    input  logic [N_DIGITS-1:0]   hex_blank,
    input  logic [N_DIGITS-1:0]   hex_blink,
    input  logic                  lz_en,
    output logic [7*N_DIGITS-1:0] hex_seg
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam int BW = $clog2(BLINK_DIV);

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [CW-1:0]     cnt [N_KEYS];

    logic [BW-1:0]     bcnt;
    logic              phase;

    logic [N_DIGITS-1:0]   lz;
    logic [7*N_DIGITS-1:0] seg_next;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Key path: sync2 is the synchronised pressed state; a change is
    // accepted only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1       <= '0;
            sync2       <= '0;
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            for (int k = 0; k < N_KEYS; k++) cnt[k] <= '0;
        end else begin
            sync1       <= ~key_n;
            sync2       <= sync1;
            key_press   <= '0;
            key_release <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                if (sync2[k] == key_level[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CW'(DEB_CYCLES - 1)) begin
                    cnt[k]         <= '0;
                    key_level[k]   <= sync2[k];
                    key_press[k]   <= sync2[k];
                    key_release[k] <= ~sync2[k];
                end else begin
                    cnt[k] <= cnt[k] + CW'(1);
                end
            end
        end
    end

    // Blink timer; phase=1 is the visible half.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (bcnt == BW'(BLINK_DIV - 1)) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt <= bcnt + BW'(1);
        end
    end

    // Suppression runs from the top digit down and stops at the first
    // non-zero nibble; digit 0 always shows.
    always_comb begin
        logic z;
        lz = '0;
        z  = lz_en;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            z     = z & (hex_data[4*i +: 4] == 4'h0);
            lz[i] = z;
        end
    end

    always_comb begin
        seg_next = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (hex_blank[i] || (hex_blink[i] && !phase) || lz[i])
                seg_next[7*i +: 7] = 7'h7F;
            else
                seg_next[7*i +: 7] = decode(hex_data[4*i +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) hex_seg <= '1;
        else       hex_seg <= seg_next;
    end

endmodule

// File: tb/tb_panel_io.sv
// tb_panel_io: directed bench for panel_io (DEB_CYCLES=4, BLINK_DIV=8,
// N_KEYS=2, N_DIGITS=4) with hand-computed expected values.
module tb_panel_io;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  key_n;
    logic [1:0]  key_level;
    logic [1:0]  key_press;
    logic [1:0]  key_release;
    logic [15:0] hex_data;
    logic [3:0]  hex_blank;
    logic [3:0]  hex_blink;
    logic        lz_en;
    logic [27:0] hex_seg;

    int checks = 0;
    int failures = 0;

    panel_io #(
        .N_KEYS(2),
        .DEB_CYCLES(4),
        .N_DIGITS(4),
        .BLINK_DIV(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_n(key_n),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release),
        .hex_data(hex_data),
        .hex_blank(hex_blank),
        .hex_blink(hex_blink),
        .lz_en(lz_en),
        .hex_seg(hex_seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic ok;
        logic [6:0] d0;

        reset     = 1'b1;
        key_n     = 2'b11;
        hex_data  = 16'h0000;
        hex_blank = 4'b0000;
        hex_blink = 4'b0000;
        lz_en     = 1'b0;
        tick(); tick(); tick();
        chk("rst_level", 32'(key_level), 32'h0);
        chk("rst_press", 32'(key_press), 32'h0);
        chk("rst_release", 32'(key_release), 32'h0);
        chk("rst_seg", 32'(hex_seg), 32'h0FFF_FFFF);
        reset = 1'b0;
        tick(); tick();

        // key 0 press: pulse on the 6th edge after the change
        key_n = 2'b10;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("k0_press", 32'(key_press[0]), 32'(k == 6));
            chk("k0_level", 32'(key_level[0]), 32'(k >= 6));
            chk("k0_norel", 32'(key_release[0]), 32'h0);
        end
        key_n = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("k0_release", 32'(key_release[0]), 32'(k == 6));
            chk("k0_level_r", 32'(key_level[0]), 32'(k < 6));
        end

        // glitch of 3 cycles on key 1
        ok = 1'b1;
        key_n = 2'b01;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (key_press[1] || key_level[1]) ok = 1'b0;
        end
        key_n = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (key_press[1] || key_level[1] || key_release[1]) ok = 1'b0;
        end
        chk("glitch_quiet", 32'(ok), 32'h1);

        // both keys pressed together
        key_n = 2'b00;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("both_press", 32'(key_press), (k == 6) ? 32'h3 : 32'h0);
        end
        key_n = 2'b11;
        for (int k = 1; k <= 10; k++) tick();
        chk("both_released", 32'(key_level), 32'h0);

        // leading-zero suppression
        hex_data = 16'h00A0;
        lz_en    = 1'b1;
        tick();
        chk("lz_on", 32'(hex_seg), 32'({7'h7F, 7'h7F, 7'h08, 7'h40}));
        lz_en = 1'b0;
        tick();
        chk("lz_off", 32'(hex_seg), 32'({7'h40, 7'h40, 7'h08, 7'h40}));
        hex_data = 16'h0000;
        lz_en    = 1'b1;
        tick();
        chk("lz_zero", 32'(hex_seg), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

        // blink on digit 0, blank on digit 3, aligned to reset
        reset     = 1'b1;
        lz_en     = 1'b0;
        hex_data  = 16'h1234;
        hex_blink = 4'b0001;
        hex_blank = 4'b1000;
        tick(); tick();
        reset = 1'b0;
        for (int j = 1; j <= 32; j++) begin
            tick();
            d0 = (((j - 1) / 8) % 2 == 0) ? 7'h19 : 7'h7F;
            chk("blink", 32'(hex_seg), 32'({7'h7F, 7'h24, 7'h30, d0}));
        end

        // reset during debounce and during blink-off phase
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int j = 1; j <= 9; j++) tick();
        chk("blink_off", 32'(hex_seg[6:0]), 32'h7F);
        key_n = 2'b10;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("rst_mid_press", 32'(key_press), 32'h0);
        chk("rst_mid_seg", 32'(hex_seg), 32'h0FFF_FFFF);
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1)
                chk("post_rst_seg", 32'(hex_seg),
                    32'({7'h7F, 7'h24, 7'h30, 7'h19}));
            chk("post_rst_press", 32'(key_press[0]), 32'(k == 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
